// File: rtl/mfp_ahb_intc.sv
// mfp_ahb_intc: AHB-Lite interrupt controller slave for the microAptiv core.
// External sources are synchronised, latched as level or rising-edge, masked
// and priority-encoded. The result drives SI_Int, IRQ_OUT and IRQ_ID.
// The bus side is a zero-wait-state slave with a 3-bit word-offset register map.
module mfp_ahb_intc #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int N_INT_OUT   = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  input  logic [N_IRQ-1:0]     IRQ_IN,
  output logic [N_INT_OUT-1:0] SI_Int,
  output logic                 IRQ_OUT,
  output logic [4:0]           IRQ_ID
);

  // Word offsets decoded from HADDR[4:2]
  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_RAW     = 3'd4;
  localparam logic [2:0] A_SWSET   = 3'd5;

  // SI_Int folding: sources are grouped in chunks of N_INT_OUT and OR-ed together
  localparam int CHUNKS = (N_IRQ + N_INT_OUT - 1) / N_INT_OUT;
  localparam int PAD_W  = CHUNKS * N_INT_OUT;

  // Lowest set index of a source vector, 0 when empty
  function automatic logic [4:0] lowest_set(input logic [N_IRQ-1:0] v);
    logic [4:0] id;
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) id = 5'(i);
    end
    return id;
  endfunction

  // Zero-extend a per-source vector to a bus word
  function automatic logic [31:0] widen(input logic [N_IRQ-1:0] v);
    logic [31:0] w;
    w = '0;
    w[N_IRQ-1:0] = v;
    return w;
  endfunction

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] mode_q;
  logic [N_IRQ-1:0] latch_q;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] wdata;
  logic [N_IRQ-1:0] latch_set;
  logic [N_IRQ-1:0] latch_clr;
  logic [PAD_W-1:0] masked_pad;
  logic [N_INT_OUT-1:0] si_fold;

  logic       vld_p1;
  logic       wr_p1;
  logic [2:0] addr_p1;
  logic       addr_ok;
  logic       wr_en;
  logic       we_pending;
  logic       we_enable;
  logic       we_mode;
  logic       we_swset;

  logic unused_bus;
  assign unused_bus = ^{HSIZE, HTRANS[0], HADDR[31:5], HADDR[1:0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // ---- stage p0: input synchroniser and edge-detect history
  // Shift IRQ_IN through SYNC_STAGES flops; prev holds last cycle's sync value
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= IRQ_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---- stage p1: AHB address phase captured for the data phase
  assign addr_ok = HSEL & HTRANS[1] & HREADY;

  // Register the accepted address phase; an abandoned transfer leaves vld_p1 low
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= addr_ok;
      wr_p1   <= HWRITE;
      addr_p1 <= HADDR[4:2];
    end
  end

  // Data-phase write strobes per register
  always_comb begin
    wr_en      = vld_p1 & wr_p1;
    wdata      = HWDATA[N_IRQ-1:0];
    we_pending = wr_en && (addr_p1 == A_PENDING);
    we_enable  = wr_en && (addr_p1 == A_ENABLE);
    we_mode    = wr_en && (addr_p1 == A_MODE);
    we_swset   = wr_en && (addr_p1 == A_SWSET);
  end

  // Latch set/clear terms; a MODE 1->0 write drops the stale edge latch
  always_comb begin
    latch_set = (mode_q & sync & ~prev_q) | (we_swset ? wdata : '0);
    latch_clr = (we_pending ? wdata : '0) | (we_mode ? (mode_q & ~wdata) : '0);
  end

  // Control registers and edge latches; set beats clear in the same cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable_q <= '0;
      mode_q   <= '0;
      latch_q  <= '0;
    end else begin
      if (we_enable) enable_q <= wdata;
      if (we_mode)   mode_q   <= wdata;
      latch_q <= (latch_q & ~latch_clr) | latch_set;
    end
  end

  // Pending view: edge sources come from the latch, level sources track sync
  always_comb begin
    pend   = (mode_q & latch_q) | (~mode_q & sync);
    masked = pend & enable_q;
  end

  // Fold masked sources onto the SI_Int vector (bit k collects i % N_INT_OUT == k)
  always_comb begin
    masked_pad = '0;
    masked_pad[N_IRQ-1:0] = masked;
    si_fold = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      si_fold = si_fold | masked_pad[c*N_INT_OUT +: N_INT_OUT];
    end
  end

  // ---- stage p2: registered interrupt outputs to the core
  // Register IRQ_OUT, IRQ_ID and SI_Int from the masked pending vector
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      IRQ_OUT <= 1'b0;
      IRQ_ID  <= '0;
      SI_Int  <= '0;
    end else begin
      IRQ_OUT <= |masked;
      IRQ_ID  <= lowest_set(masked);
      SI_Int  <= si_fold;
    end
  end

  // Read data driven from the registered address only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (vld_p1 && !wr_p1) begin
      case (addr_p1)
        A_PENDING: HRDATA = widen(pend);
        A_ENABLE:  HRDATA = widen(enable_q);
        A_MODE:    HRDATA = widen(mode_q);
        A_STATUS:  HRDATA = {IRQ_OUT, 26'd0, IRQ_ID};
        A_RAW:     HRDATA = widen(sync);
        default:   HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_intc.sv
// tb_mfp_ahb_intc: directed bench for mfp_ahb_intc with a queue-based scoreboard.
// u0 uses default parameters, u1 uses N_IRQ=32 to exercise source folding.
module tb_mfp_ahb_intc;

  localparam logic [31:0] R_PENDING = 32'h00;
  localparam logic [31:0] R_ENABLE  = 32'h04;
  localparam logic [31:0] R_MODE    = 32'h08;
  localparam logic [31:0] R_STATUS  = 32'h0C;
  localparam logic [31:0] R_RAW     = 32'h10;
  localparam logic [31:0] R_SWSET   = 32'h14;

  logic        clk = 1'b0;
  logic        HRESETn;
  logic        HSEL0, HSEL1;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;

  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1, hresp0, hresp1;
  logic [7:0]  irq0;
  logic [31:0] irq1;
  logic [7:0]  si0, si1;
  logic        irq_out0, irq_out1;
  logic [4:0]  id0, id1;

  always #5 clk = ~clk;

  mfp_ahb_intc u0 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0),
    .IRQ_IN(irq0), .SI_Int(si0), .IRQ_OUT(irq_out0), .IRQ_ID(id0)
  );

  mfp_ahb_intc #(.N_IRQ(32), .SYNC_STAGES(2), .N_INT_OUT(8)) u1 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(HSEL1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1),
    .IRQ_IN(irq1), .SI_Int(si1), .IRQ_OUT(irq_out1), .IRQ_ID(id1)
  );

  typedef struct {
    logic [31:0] data;
    string       name;
  } rd_exp_t;

  typedef struct {
    int          dut;
    logic        out;
    logic [4:0]  id;
    logic [7:0]  si;
    string       name;
  } sb_exp_t;

  rd_exp_t rd_q[$];
  sb_exp_t sb_q[$];
  rd_exp_t rd_e;
  sb_exp_t sb_e;

  int   errors = 0;
  int   checks = 0;
  logic probe  = 1'b0;
  logic rd_phase;
  logic        act_out;
  logic [4:0]  act_id;
  logic [7:0]  act_si;

  // Track read data phases of u0 as seen on the bus
  always @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) rd_phase <= 1'b0;
    else          rd_phase <= HSEL0 & HTRANS[1] & HREADY & ~HWRITE;
  end

  // Monitor: read data and sideband probes are compared against queued expectations
  always @(negedge clk) begin
    if (rd_phase) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read hrdata=%h", hrdata0);
      end else begin
        rd_e = rd_q.pop_front();
        if (hrdata0 !== rd_e.data || hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin
          errors++;
          $display("FAIL %s hrdata=%h hreadyout=%b hresp=%b required hrdata=%h hreadyout=1 hresp=0",
                   rd_e.name, hrdata0, hreadyout0, hresp0, rd_e.data);
        end
      end
    end
    if (probe) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_probe");
      end else begin
        sb_e = sb_q.pop_front();
        if (sb_e.dut == 0) begin
          act_out = irq_out0; act_id = id0; act_si = si0;
        end else begin
          act_out = irq_out1; act_id = id1; act_si = si1;
        end
        if (act_out !== sb_e.out || act_id !== sb_e.id || act_si !== sb_e.si) begin
          errors++;
          $display("FAIL %s irq_out=%b irq_id=%0d si_int=%h required irq_out=%b irq_id=%0d si_int=%h",
                   sb_e.name, act_out, act_id, act_si, sb_e.out, sb_e.id, sb_e.si);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ahb_write(input int sel, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    HSEL0 = (sel == 0); HSEL1 = (sel == 1); HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge clk); #1;
    HWDATA = d; HSEL0 = 1'b0; HSEL1 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    rd_q.push_back('{exp, nm});
    @(posedge clk); #1;
    HSEL0 = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge clk); #1;
    HSEL0 = 1'b0; HTRANS = 2'b00; HADDR = '0;
  endtask

  task automatic check_sb(input int dut, input logic o, input logic [4:0] id,
                          input logic [7:0] si, input string nm);
    sb_q.push_back('{dut, o, id, si, nm});
    probe = 1'b1;
    @(negedge clk); #1;
    probe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSEL0 = 1'b0; HSEL1 = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = '0; HREADY = 1'b1; irq0 = '0; irq1 = '0;

    // Reset state
    check_sb(0, 1'b0, 5'd0, 8'h00, "reset_outputs");
    tick(2);
    HRESETn = 1'b1;
    ahb_read(R_ENABLE,  32'h0, "reset_enable");
    ahb_read(R_MODE,    32'h0, "reset_mode");
    ahb_read(R_PENDING, 32'h0, "reset_pending");
    ahb_read(R_STATUS,  32'h0, "reset_status");

    // Level source: IRQ_OUT on edge 3, W1C ineffective, drop seen on edge 3
    ahb_write(0, R_ENABLE, 32'h01);
    irq0 = 8'h01;
    tick(2);
    check_sb(0, 1'b0, 5'd0, 8'h00, "lvl_edge2");
    tick(1);
    check_sb(0, 1'b1, 5'd0, 8'h01, "lvl_edge3");
    ahb_write(0, R_PENDING, 32'h01);
    tick(2);
    check_sb(0, 1'b1, 5'd0, 8'h01, "lvl_w1c_ignored");
    ahb_read(R_PENDING, 32'h01, "lvl_pending");
    irq0 = 8'h00;
    tick(2);
    check_sb(0, 1'b1, 5'd0, 8'h01, "lvl_drop_edge2");
    tick(1);
    check_sb(0, 1'b0, 5'd0, 8'h00, "lvl_drop_edge3");

    // Edge source: 2-cycle pulse on bit 5, IRQ_OUT on edge 4, W1C clears
    ahb_write(0, R_MODE, 32'hFF);
    ahb_write(0, R_ENABLE, 32'h20);
    irq0 = 8'h20;
    tick(2);
    irq0 = 8'h00;
    check_sb(0, 1'b0, 5'd0, 8'h00, "edge_edge2");
    tick(1);
    check_sb(0, 1'b0, 5'd0, 8'h00, "edge_edge3");
    tick(1);
    check_sb(0, 1'b1, 5'd5, 8'h20, "edge_edge4");
    ahb_read(R_PENDING, 32'h20, "edge_pending");
    ahb_read(R_STATUS, 32'h8000_0005, "edge_status");
    ahb_write(0, R_PENDING, 32'h20);
    tick(1);
    check_sb(0, 1'b1, 5'd5, 8'h20, "w1c_same_edge");
    tick(1);
    check_sb(0, 1'b0, 5'd0, 8'h00, "w1c_next_edge");

    // Priority and set-beats-clear
    ahb_write(0, R_ENABLE, 32'h48);
    ahb_write(0, R_SWSET, 32'h48);
    tick(2);
    check_sb(0, 1'b1, 5'd3, 8'h48, "priority_3_over_6");
    irq0 = 8'h08;
    ahb_write(0, R_PENDING, 32'h08);
    tick(2);
    check_sb(0, 1'b1, 5'd3, 8'h48, "set_beats_clear");
    ahb_read(R_PENDING, 32'h48, "set_beats_clear_pend");
    irq0 = 8'h00;

    // Masking, SWSET, MODE fall clears latch, reserved bits
    ahb_write(0, R_ENABLE, 32'h00);
    ahb_write(0, R_SWSET, 32'hFF);
    tick(2);
    check_sb(0, 1'b0, 5'd0, 8'h00, "masked_all");
    ahb_read(R_STATUS, 32'h0, "masked_status");
    ahb_read(R_PENDING, 32'hFF, "masked_pending");
    ahb_write(0, R_PENDING, 32'hFF);
    ahb_write(0, R_ENABLE, 32'h80);
    tick(2);
    check_sb(0, 1'b0, 5'd0, 8'h00, "all_cleared");
    ahb_write(0, R_SWSET, 32'h80);
    tick(2);
    check_sb(0, 1'b1, 5'd7, 8'h80, "swset_bit7");
    ahb_read(R_SWSET, 32'h0, "swset_reads_zero");
    ahb_write(0, R_MODE, 32'h7F);
    ahb_write(0, R_MODE, 32'hFF);
    ahb_read(R_PENDING, 32'h00, "mode_fall_clears");
    ahb_write(0, R_ENABLE, 32'hFFFF_FFFF);
    ahb_read(R_ENABLE, 32'h0000_00FF, "enable_upper_bits");
    ahb_read(R_MODE, 32'h0000_00FF, "mode_readback");
    ahb_read(R_RAW, 32'h0, "raw_idle");

    // Back-to-back write then read of ENABLE
    @(posedge clk); #1;
    HSEL0 = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = R_ENABLE;
    rd_q.push_back('{32'h0F, "back_to_back"});
    @(posedge clk); #1;
    HWDATA = 32'h0F; HWRITE = 1'b0; HADDR = R_ENABLE;
    @(posedge clk); #1;
    HSEL0 = 1'b0; HTRANS = 2'b00; HADDR = '0;

    // Reserved offsets and IDLE transfers
    ahb_read(32'h1C, 32'h0, "reserved_1c");
    ahb_write(0, 32'h1C, 32'hFFFF_FFFF);
    ahb_read(32'h18, 32'h0, "reserved_18");
    @(posedge clk); #1;
    HSEL0 = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = R_ENABLE;
    @(posedge clk); #1;
    HSEL0 = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = 32'hFFFF_FFFF;
    ahb_read(R_ENABLE, 32'h0F, "idle_no_write");

    // 32-source instance: source 31 folds onto SI_Int[7]
    ahb_write(1, R_ENABLE, 32'h8000_0000);
    irq1 = 32'h8000_0000;
    tick(2);
    check_sb(1, 1'b0, 5'd0, 8'h00, "n32_edge2");
    tick(1);
    check_sb(1, 1'b1, 5'd31, 8'h80, "n32_src31");

    // Reset asserted in the data phase of a write
    ahb_write(0, R_SWSET, 32'h01);
    tick(2);
    check_sb(0, 1'b1, 5'd0, 8'h01, "pre_reset_u0");
    @(posedge clk); #1;
    HSEL0 = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = R_ENABLE;
    @(posedge clk); #1;
    HSEL0 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = 32'hAA;
    HRESETn = 1'b0;
    check_sb(0, 1'b0, 5'd0, 8'h00, "in_reset_u0");
    check_sb(1, 1'b0, 5'd0, 8'h00, "in_reset_u1");
    irq1 = '0;
    tick(2);
    HRESETn = 1'b1;
    ahb_read(R_ENABLE,  32'h0, "post_reset_enable");
    ahb_read(R_MODE,    32'h0, "post_reset_mode");
    ahb_read(R_PENDING, 32'h0, "post_reset_pending");
    ahb_read(R_STATUS,  32'h0, "post_reset_status");
    tick(1);
    check_sb(0, 1'b0, 5'd0, 8'h00, "post_reset_outputs");

    tick(3);
    checks++;
    if (rd_q.size() != 0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain reads_left=%0d probes_left=%0d required 0 and 0",
               rd_q.size(), sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
